// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    // Default program capacity in 32-bit words.
    localparam int DEF_MEM_WORDS = 1024;

    // Width of the little-endian length field that precedes the program bytes.
    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } loaderState_t;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and flags the byte
// that completes a word.
module word_packer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear,
    input  logic        byteEn,
    input  logic [7:0]  inByte,
    output logic [31:0] word,
    output logic        wordDone
);

    logic [1:0]  byteCnt;
    logic [31:0] asmReg;

    // The complete word is the three stored lanes plus the byte arriving now.
    always_comb begin
        word        = asmReg;
        word[31:24] = inByte;
    end

    assign wordDone = byteEn && (byteCnt == 2'd3);

    // Byte lanes and counter only move on accepted bytes, so gaps hold the partial word.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            byteCnt <= '0;
            asmReg  <= '0;
        end else if (clear) begin
            byteCnt <= '0;
            asmReg  <= '0;
        end else if (byteEn) begin
            asmReg[{byteCnt, 3'b000} +: 8] <= inByte;
            byteCnt                        <= byteCnt + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a 16-bit word count followed by program bytes,
// writes each assembled word to instruction memory, then releases the CPU.
//
// Byte handshake: a byte transfers on a rising Clk edge where In_Valid and
// In_Ready are both 1; In_Data is ignored otherwise. In_Ready depends only on
// the registered state, never on In_Valid.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic              IMem_WrEn,
    output logic [ADDR_W-1:0] IMem_Addr,
    output logic [31:0]       IMem_WrData,
    output logic              CPU_Run,
    output logic              Load_Err,
    output logic [ADDR_W:0]   Word_Count
);

    loaderState_t     state, nextState;
    logic [LEN_W-1:0] lenReg;
    logic [LEN_W-1:0] lenFull;
    logic             byteTake;
    logic             startTake;
    logic             dataByte;
    logic             wordDone;
    logic             lastWord;
    logic [31:0]      packedWord;

    assign byteTake  = In_Valid && In_Ready;
    // Start only counts when no load is in progress.
    assign startTake = Start && (state == IDLE || state == DONE || state == ERR);
    assign dataByte  = byteTake && (state == DATA);
    assign lenFull   = {In_Data, lenReg[7:0]};
    assign lastWord  = (32'(Word_Count) + 32'd1) == 32'(lenReg);

    word_packer u_packer (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (startTake),
        .byteEn   (dataByte),
        .inByte   (In_Data),
        .word     (packedWord),
        .wordDone (wordDone)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (Start) nextState = LEN_LO;
            end
            LEN_LO: begin
                if (byteTake) nextState = LEN_HI;
            end
            LEN_HI: begin
                if (byteTake) begin
                    if (lenFull == '0) begin
                        nextState = DONE;
                    end else if (32'(lenFull) > 32'(MEM_WORDS)) begin
                        nextState = ERR;
                    end else begin
                        nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (wordDone && lastWord) nextState = DONE;
            end
            DONE, ERR: begin
                if (Start) nextState = LEN_LO;
            end
            default: nextState = IDLE;
        endcase
    end

    // Registered outputs, length capture and memory write port.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            In_Ready    <= 1'b0;
            IMem_WrEn   <= 1'b0;
            IMem_Addr   <= '0;
            IMem_WrData <= '0;
            CPU_Run     <= 1'b0;
            Load_Err    <= 1'b0;
            Word_Count  <= '0;
            lenReg      <= '0;
        end else begin
            In_Ready  <= (nextState == LEN_LO) || (nextState == LEN_HI) || (nextState == DATA);
            Load_Err  <= (nextState == ERR);
            // Run lags DONE entry by one edge so it follows the final write.
            CPU_Run   <= (state == DONE) && !Start;
            IMem_WrEn <= 1'b0;

            if (byteTake && state == LEN_LO) lenReg[7:0]  <= In_Data;
            if (byteTake && state == LEN_HI) lenReg[15:8] <= In_Data;

            if (startTake) begin
                Word_Count <= '0;
            end else if (wordDone) begin
                IMem_WrEn   <= 1'b1;
                IMem_Addr   <= Word_Count[ADDR_W-1:0];
                IMem_WrData <= packedWord;
                Word_Count  <= Word_Count + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of whole loads plus hand-written
// reset-mid-load and start-while-busy sequences; memory writes are checked
// against an expected queue filled as the bytes are driven.
module tb_prog_loader;

    localparam int ADDR_W    = 10;
    localparam int MEM_WORDS = 1024;
    localparam int W         = ADDR_W + 32;

    logic              Clk      = 1'b0;
    logic              Reset    = 1'b0;
    logic              Start    = 1'b0;
    logic [7:0]        In_Data  = 8'h00;
    logic              In_Valid = 1'b0;
    logic              In_Ready;
    logic              IMem_WrEn;
    logic [ADDR_W-1:0] IMem_Addr;
    logic [31:0]       IMem_WrData;
    logic              CPU_Run;
    logic              Load_Err;
    logic [ADDR_W:0]   Word_Count;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] popVal;
    int           wrCyc[$];
    int           runCyc  = -1;
    logic         prevRun = 1'b0;
    int           cyc     = 0;
    int           nVec    = 0;
    int           nBad    = 0;

    typedef struct {
        logic [15:0] len;
        int          gap;
        bit          nominal;
        bit          expRun;
        bit          expErr;
        int          expCount;
    } vec_t;

    vec_t vecs[7];

    prog_loader dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .In_Data     (In_Data),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .IMem_WrEn   (IMem_WrEn),
        .IMem_Addr   (IMem_Addr),
        .IMem_WrData (IMem_WrData),
        .CPU_Run     (CPU_Run),
        .Load_Err    (Load_Err),
        .Word_Count  (Word_Count)
    );

    // Clock and cycle counter.
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nVec++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge Clk) begin
        if (IMem_WrEn) begin
            if (exp_q.size() == 0) begin
                nVec++;
                nBad++;
                $display("FAIL unexpected_write: addr %0h data %08h, expected no write", IMem_Addr, IMem_WrData);
            end else begin
                popVal = exp_q.pop_front();
                check("mem_write", {IMem_Addr, IMem_WrData}, popVal);
            end
            wrCyc.push_back(cyc);
        end
        if (CPU_Run && !prevRun) runCyc = cyc;
        prevRun = CPU_Run;
    end

    // Driver tasks: inputs change 1 time unit after the falling edge.
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int guard = 0;
        In_Data  = b;
        In_Valid = 1'b1;
        while (!In_Ready && guard < 16) begin
            tick();
            guard++;
        end
        if (!In_Ready) begin
            nVec++;
            nBad++;
            $display("FAIL ready_timeout: In_Ready 0 after 16 cycles, byte %02h required acceptance", b);
        end
        tick();
        if (gap > 0) begin
            In_Valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic sendWord(input int k, input logic [31:0] w, input int gap);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(k);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back({a, w});
            sendByte(w[8*b +: 8], gap);
        end
    endtask

    task automatic doLoad(input logic [15:0] len, input int gap, input bit nominal,
                          output logic [31:0] lastW);
        logic [31:0] w;
        lastW = '0;
        wrCyc.delete();
        runCyc = -1;
        pulseStart();
        check("start_clr_err", Load_Err, 0);
        check("start_clr_run", CPU_Run, 0);
        check("start_clr_count", Word_Count, 0);
        check("start_ready", In_Ready, 1);
        sendByte(len[7:0], gap);
        sendByte(len[15:8], gap);
        if (len == 0) begin
            In_Valid = 1'b0;
            check("zero_run_early", CPU_Run, 0);
            tick();
            check("zero_run", CPU_Run, 1);
        end else if (32'(len) <= 32'(MEM_WORDS)) begin
            for (int k = 0; k < int'(len); k++) begin
                if (nominal) w = (k == 0) ? 32'h0000_0013 : 32'h0010_0093;
                else         w = $urandom;
                sendWord(k, w, gap);
                lastW = w;
            end
        end
        In_Valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lastW;
        logic [31:0] w0;
        logic [31:0] w1;

        vecs[0] = '{16'd2,     0, 1'b1, 1'b1, 1'b0, 2};
        vecs[1] = '{16'd0,     0, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{16'd1025,  0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{16'd1,     3, 1'b0, 1'b1, 1'b0, 1};
        vecs[4] = '{16'd3,     $urandom_range(1, 2), 1'b0, 1'b1, 1'b0, 3};
        vecs[5] = '{16'd1024,  0, 1'b0, 1'b1, 1'b0, 1024};
        vecs[6] = '{16'hFFFF,  0, 1'b0, 1'b0, 1'b1, 0};

        // Reset state.
        #3;
        check("rst_ready", In_Ready, 0);
        check("rst_wren", IMem_WrEn, 0);
        check("rst_addr", IMem_Addr, 0);
        check("rst_data", IMem_WrData, 0);
        check("rst_run", CPU_Run, 0);
        check("rst_err", Load_Err, 0);
        check("rst_count", Word_Count, 0);
        tick();
        Reset = 1'b1;
        tick();
        check("idle_ready", In_Ready, 0);

        // Table of whole loads.
        for (int i = 0; i < 7; i++) begin
            doLoad(vecs[i].len, vecs[i].gap, vecs[i].nominal, lastW);
            repeat (3) tick();
            check("final_run", CPU_Run, vecs[i].expRun);
            check("final_err", Load_Err, vecs[i].expErr);
            check("final_count", Word_Count, vecs[i].expCount);
            check("final_ready", In_Ready, 0);
            check("queue_drained", exp_q.size(), 0);
            if (vecs[i].expCount != 0) begin
                check("hold_addr", IMem_Addr, vecs[i].expCount - 1);
                check("hold_data", IMem_WrData, lastW);
            end
            if (vecs[i].nominal) begin
                check("nominal_writes", wrCyc.size(), 2);
                if (wrCyc.size() == 2) begin
                    check("nominal_spacing", wrCyc[1] - wrCyc[0], 4);
                    check("nominal_run_delay", runCyc - wrCyc[1], 1);
                end
            end
        end

        // Start pulses while in LEN_HI and DATA must be ignored.
        w0 = $urandom;
        w1 = $urandom;
        pulseStart();
        sendByte(8'd2, 0);
        In_Valid = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("busy_lenhi_ready", In_Ready, 1);
        sendByte(8'd0, 0);
        sendByte(w0[7:0], 0);
        sendByte(w0[15:8], 0);
        In_Valid = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        sendByte(w0[23:16], 0);
        exp_q.push_back({10'd0, w0});
        sendByte(w0[31:24], 0);
        sendWord(1, w1, 0);
        In_Valid = 1'b0;
        repeat (3) tick();
        check("busy_count", Word_Count, 2);
        check("busy_run", CPU_Run, 1);
        check("busy_data", IMem_WrData, w1);
        check("busy_queue", exp_q.size(), 0);

        // Reset in the middle of the second word.
        w0 = $urandom;
        w1 = $urandom;
        pulseStart();
        sendByte(8'd2, 0);
        sendByte(8'd0, 0);
        sendWord(0, w0, 0);
        sendByte(w1[7:0], 0);
        sendByte(w1[15:8], 0);
        Reset = 1'b0;
        #1;
        check("midrst_ready", In_Ready, 0);
        check("midrst_wren", IMem_WrEn, 0);
        check("midrst_addr", IMem_Addr, 0);
        check("midrst_data", IMem_WrData, 0);
        check("midrst_run", CPU_Run, 0);
        check("midrst_err", Load_Err, 0);
        check("midrst_count", Word_Count, 0);
        In_Valid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        check("midrst_idle", In_Ready, 0);
        doLoad(16'd2, 0, 1'b0, lastW);
        repeat (3) tick();
        check("reload_count", Word_Count, 2);
        check("reload_run", CPU_Run, 1);
        check("reload_addr", IMem_Addr, 1);
        check("reload_data", IMem_WrData, lastW);
        check("reload_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
